// File: rtl/pb_event_arbiter.sv
// Push-button front end: per-channel 2-flop sync + debounce, pending-press latch, round-robin event port.
// Optional PB_RELEASE_EVT_EN adds release events (evt_rel) alongside presses.

module pb_debounce #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic lvl,
    output logic upd
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             s1, s2, stable;
    logic [CNT_W-1:0] cnt;

    // upd marks the edge on which the synced level is accepted as the new stable level
    assign lvl = s2;
    assign upd = (s2 != stable) && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= pb;
            s2 <= s1;
            if (s2 != stable) begin
                if (cnt == CNT_MAX) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module pb_event_arbiter #(
    parameter  int NUM_PB    = 4,
    parameter  int DB_CYCLES = 16,
    localparam int ID_W      = $clog2(NUM_PB),
    localparam int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_PB-1:0] pb,
    output logic              evt_vld,
    output logic [ID_W-1:0]   evt_id,
    input  logic              evt_rdy,
`ifdef PB_RELEASE_EVT_EN
    output logic              evt_rel,
`endif
    output logic [NUM_PB-1:0] pend,
    output logic              ovf,
    input  logic              ovf_clr
);
    typedef enum logic {IDLE, OFFER} state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr, pick;
    logic [NUM_PB-1:0] lvl, upd, rise, req, clr_p;
    logic              xfer, ovf_set;

    for (genvar g = 0; g < NUM_PB; g++) begin : g_ch
        pb_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
            .clk (clk),
            .rst (rst),
            .pb  (pb[g]),
            .lvl (lvl[g]),
            .upd (upd[g])
        );
    end

    assign rise = upd & lvl;
    assign xfer = evt_vld & evt_rdy;

`ifdef PB_RELEASE_EVT_EN
    logic [NUM_PB-1:0] fall, rel_pend, clr_r;

    assign fall = upd & ~lvl;
    assign req  = pend | rel_pend;

    always_comb begin
        clr_p = '0;
        clr_r = '0;
        clr_p[evt_id] = xfer & ~evt_rel;
        clr_r[evt_id] = xfer & evt_rel;
    end

    assign ovf_set = |(rise & pend & ~clr_p) | |(fall & rel_pend & ~clr_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rel_pend <= '0;
        else     rel_pend <= (rel_pend & ~clr_r) | fall;
    end
`else
    assign req = pend;

    always_comb begin
        clr_p = '0;
        clr_p[evt_id] = xfer;
    end

    assign ovf_set = |(rise & pend & ~clr_p);
`endif

    // first requesting channel at or after ptr, wrapping; lowest offset wins
    always_comb begin
        int idx;
        pick = '0;
        for (int k = NUM_PB - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_PB;
            if (req[idx]) pick = ID_W'(idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            evt_vld <= 1'b0;
            evt_id  <= '0;
            ptr     <= '0;
            pend    <= '0;
            ovf     <= 1'b0;
`ifdef PB_RELEASE_EVT_EN
            evt_rel <= 1'b0;
`endif
        end else begin
            pend <= (pend & ~clr_p) | rise;
            ovf  <= (ovf & ~ovf_clr) | ovf_set;
            case (state)
                IDLE: begin
                    if (|req) begin
                        evt_id  <= pick;
                        evt_vld <= 1'b1;
                        state   <= OFFER;
`ifdef PB_RELEASE_EVT_EN
                        evt_rel <= ~pend[pick];
`endif
                    end
                end
                OFFER: begin
                    if (evt_rdy) begin
                        evt_vld <= 1'b0;
                        ptr     <= (evt_id == ID_W'(NUM_PB - 1)) ? '0 : evt_id + 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pb_event_arbiter.sv
// Bench for pb_event_arbiter (NUM_PB=4, DB_CYCLES=4): vector table, corner sequences, random vs model.
module tb_pb_event_arbiter;
    localparam int NPB = 4;
    localparam int DB  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [NPB-1:0] pb;
    logic           evt_vld;
    logic [1:0]     evt_id;
    logic           evt_rdy;
    logic [NPB-1:0] pend;
    logic           ovf;
    logic           ovf_clr;
`ifdef PB_RELEASE_EVT_EN
    logic           evt_rel;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pb_event_arbiter #(.NUM_PB(NPB), .DB_CYCLES(DB)) dut (
        .clk     (clk),
        .rst     (rst),
        .pb      (pb),
        .evt_vld (evt_vld),
        .evt_id  (evt_id),
        .evt_rdy (evt_rdy),
`ifdef PB_RELEASE_EVT_EN
        .evt_rel (evt_rel),
`endif
        .pend    (pend),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    typedef struct {
        logic [3:0] pb;
        logic       rdy;
        logic       clr;
        int         n;
        logic       vld;
        logic [1:0] id;
        logic [3:0] pend;
        logic       ovf;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(logic [3:0] p, logic r, logic c, int n,
                               logic ev, logic [1:0] ei, logic [3:0] ep, logic eo);
        vec_t t;
        t.pb = p; t.rdy = r; t.clr = c; t.n = n;
        t.vld = ev; t.id = ei; t.pend = ep; t.ovf = eo;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // reference model: per-channel run length of disagreeing samples, pending set, round-robin search
    logic       m_s1[NPB], m_s2[NPB], m_stab[NPB];
    int         m_run[NPB];
    logic [3:0] m_pend;
    logic       m_ovf, m_vld;
    int         m_id, m_ptr;

    task automatic model_reset();
        for (int i = 0; i < NPB; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_stab[i] = 0; m_run[i] = 0;
        end
        m_pend = 0; m_ovf = 0; m_vld = 0; m_id = 0; m_ptr = 0;
    endtask

    task automatic model_step(input logic [3:0] p, input logic r, input logic c);
        logic [3:0] press, clrm, old_pend;
        press = 0;
        clrm  = 0;
        for (int i = 0; i < NPB; i++) begin
            if (m_s2[i] != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_stab[i] = m_s2[i];
                    m_run[i]  = 0;
                    press[i]  = m_stab[i];
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = p[i];
        end
        if (m_vld && r) clrm[m_id] = 1'b1;
        m_ovf    = (m_ovf && !c) || ((press & m_pend & ~clrm) != 0);
        old_pend = m_pend;
        m_pend   = (m_pend & ~clrm) | press;
        if (m_vld && r) begin
            m_vld = 0;
            m_ptr = (m_id + 1) % NPB;
        end else if (!m_vld && old_pend != 0) begin
            for (int k = NPB - 1; k >= 0; k--)
                if (old_pend[(m_ptr + k) % NPB]) m_id = (m_ptr + k) % NPB;
            m_vld = 1;
        end
    endtask

    initial begin
        int ids[$];
        int at[$];
        int rels[$];
        int nvld;

        rst = 1'b1; pb = '0; evt_rdy = 1'b0; ovf_clr = 1'b0;
        cyc(3);
        chk("rst_vld",  evt_vld, 0);
        chk("rst_id",   evt_id,  0);
        chk("rst_pend", pend,    0);
        chk("rst_ovf",  ovf,     0);
        rst = 1'b0;

        // press timing, wrap-around from ptr=3, held offer with overflow, glitch rejection
        tv.push_back(v(4'b0100, 1, 0, 5,  0, 0, 4'b0000, 0));
        tv.push_back(v(4'b0100, 1, 0, 1,  0, 0, 4'b0100, 0));
        tv.push_back(v(4'b0100, 1, 0, 1,  1, 2, 4'b0100, 0));
        tv.push_back(v(4'b0100, 1, 0, 1,  0, 0, 4'b0000, 0));
        tv.push_back(v(4'b0100, 1, 0, 3,  0, 0, 4'b0000, 0));
        tv.push_back(v(4'b1101, 1, 0, 6,  0, 0, 4'b1001, 0));
        tv.push_back(v(4'b1101, 1, 0, 1,  1, 3, 4'b1001, 0));
        tv.push_back(v(4'b1101, 1, 0, 1,  0, 0, 4'b0001, 0));
        tv.push_back(v(4'b1101, 1, 0, 1,  1, 0, 4'b0001, 0));
        tv.push_back(v(4'b1101, 1, 0, 1,  0, 0, 4'b0000, 0));
        tv.push_back(v(4'b1101, 1, 0, 4,  0, 0, 4'b0000, 0));
        tv.push_back(v(4'b1111, 0, 0, 6,  0, 0, 4'b0010, 0));
        tv.push_back(v(4'b1111, 0, 0, 1,  1, 1, 4'b0010, 0));
        tv.push_back(v(4'b1111, 0, 0, 20, 1, 1, 4'b0010, 0));
        tv.push_back(v(4'b1101, 0, 0, 8,  1, 1, 4'b0010, 0));
        tv.push_back(v(4'b1111, 0, 0, 5,  1, 1, 4'b0010, 0));
        tv.push_back(v(4'b1111, 0, 0, 1,  1, 1, 4'b0010, 1));
        tv.push_back(v(4'b1111, 0, 1, 1,  1, 1, 4'b0010, 0));
        tv.push_back(v(4'b1111, 1, 0, 1,  0, 0, 4'b0000, 0));
        tv.push_back(v(4'b1111, 1, 0, 4,  0, 0, 4'b0000, 0));
`ifndef PB_RELEASE_EVT_EN
        tv.push_back(v(4'b1101, 1, 0, 8,  0, 0, 4'b0000, 0));
        tv.push_back(v(4'b1111, 1, 0, 3,  0, 0, 4'b0000, 0));
        tv.push_back(v(4'b1101, 1, 0, 6,  0, 0, 4'b0000, 0));
`endif
        foreach (tv[i]) begin
            pb = tv[i].pb; evt_rdy = tv[i].rdy; ovf_clr = tv[i].clr;
            cyc(tv[i].n);
            chk($sformatf("vec%0d_vld", i), evt_vld, tv[i].vld);
            if (tv[i].vld) chk($sformatf("vec%0d_id", i), evt_id, tv[i].id);
            chk($sformatf("vec%0d_pend", i), pend, tv[i].pend);
            chk($sformatf("vec%0d_ovf", i),  ovf,  tv[i].ovf);
        end
        ovf_clr = 1'b0;

        // async reset while an offer is held
        evt_rdy = 1'b1; pb = 4'b0000;
        cyc(16);
        evt_rdy = 1'b0; pb = 4'b0010;
        for (int k = 0; k < 20 && !evt_vld; k++) cyc(1);
        chk("pre_rst_offer_vld", evt_vld, 1);
        chk("pre_rst_offer_id",  evt_id,  1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_vld",  evt_vld, 0);
        chk("async_rst_pend", pend,    0);
        chk("async_rst_ovf",  ovf,     0);
        pb = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
        nvld = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (evt_vld) nvld++;
        end
        chk("no_evt_after_rst", nvld, 0);

        // all four together from ptr=0: served 0,1,2,3 two cycles apart
        pb = 4'b1111; evt_rdy = 1'b1;
        ids.delete(); at.delete();
        for (int k = 0; k < 30; k++) begin
            cyc(1);
            if (evt_vld) begin ids.push_back(evt_id); at.push_back(k); end
        end
        chk("rr4_count", ids.size(), 4);
        for (int j = 0; j < 4 && j < ids.size(); j++) begin
            chk($sformatf("rr4_id%0d", j), ids[j], j);
            if (j > 0) chk($sformatf("rr4_gap%0d", j), at[j] - at[j-1], 2);
        end

        // press then release on channel 0
        pb = 4'b0000;
        cyc(16);
        ids.delete(); rels.delete();
        for (int k = 0; k < 26; k++) begin
            pb = (k < 10) ? 4'b0001 : 4'b0000;
            cyc(1);
            if (evt_vld) begin
                ids.push_back(evt_id);
`ifdef PB_RELEASE_EVT_EN
                rels.push_back(evt_rel);
`endif
            end
        end
`ifdef PB_RELEASE_EVT_EN
        chk("rel_count", ids.size(), 2);
        if (ids.size() == 2) begin
            chk("rel_id0", ids[0], 0);  chk("rel_id1", ids[1], 0);
            chk("rel_kind0", rels[0], 0); chk("rel_kind1", rels[1], 1);
        end
`else
        chk("press_only_count", ids.size(), 1);
        if (ids.size() == 1) chk("press_only_id", ids[0], 0);
`endif

`ifndef PB_RELEASE_EVT_EN
        // randomized traffic against the reference model
        rst = 1'b1; pb = '0; evt_rdy = 1'b0; ovf_clr = 1'b0;
        cyc(2);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] np;
            np = pb;
            for (int i = 0; i < NPB; i++)
                if ($urandom_range(0, 7) == 0) np[i] = ~np[i];
            pb      = np;
            evt_rdy = ($urandom_range(0, 2) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            model_step(pb, evt_rdy, ovf_clr);
            cyc(1);
            chk($sformatf("rand%0d", c),
                {evt_vld, (evt_vld ? evt_id : 2'd0), pend, ovf},
                {m_vld, (m_vld ? 2'(m_id) : 2'd0), m_pend, m_ovf});
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
